iic_xfer_seq: RTL and testbench

IIC_XFER_SEQ -- requirements
Module: iic_xfer_seq

---
 rtl/iic_xfer_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_iic_xfer_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_xfer_seq.sv
// I2C transfer sequencer: turns host commands plus TX/RX byte FIFOs into start/stop byte requests for a byte engine.
// One command at a time (cmd_ready only in IDLE); payload issue stalls while TX is empty (write) or RX is full (read).

module iic_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_ok;
    logic          pop_ok;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    // Head is read straight from storage so a pop on empty leaves it untouched.
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

module iic_xfer_seq #(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [1:0] BUS_MODE   = 2'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev_addr,
    input  logic [3:0] cmd_len,
    input  logic       tx_wr,
    input  logic [7:0] tx_data,
    output logic       tx_full,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       busy,
    output logic       xfer_done,
    output logic       nack_err,
    output logic       m_rw,
    output logic [1:0] m_mode,
    output logic [7:0] m_data,
    output logic       m_start,
    output logic       m_stop,
    input  logic       m_proc_ing,
    input  logic       m_done,
    input  logic [7:0] m_data_out,
    input  logic       m_ack
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACC,
        WAIT_DONE,
        STOP,
        FIN
    } state_t;

    state_t     state;
    logic       rw_q;
    logic [6:0] addr_q;
    logic [3:0] len_q;
    logic [3:0] idx_q;
    logic       addr_phase;

    logic       tx_empty;
    logic [7:0] tx_head;
    logic       tx_pop;
    logic       rx_full;
    logic       rx_push;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign m_mode    = BUS_MODE;

    assign tx_pop  = (state == ISSUE) && !addr_phase && !rw_q && !tx_empty;
    assign rx_push = (state == WAIT_DONE) && m_done && !addr_phase && rw_q;

    iic_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_wr),
        .push_dat (tx_data),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    iic_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (m_data_out),
        .pop      (rx_rd),
        .head_dat (rx_data),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            addr_phase <= 1'b0;
            nack_err   <= 1'b0;
            m_start    <= 1'b0;
            m_stop     <= 1'b0;
            m_rw       <= 1'b0;
            m_data     <= '0;
            xfer_done  <= 1'b0;
        end else begin
            m_stop    <= 1'b0;
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rw_q       <= cmd_rw;
                        addr_q     <= cmd_dev_addr;
                        len_q      <= cmd_len;
                        idx_q      <= '0;
                        addr_phase <= 1'b1;
                        nack_err   <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (addr_phase) begin
                        m_data  <= {addr_q, rw_q};
                        m_rw    <= 1'b0;
                        m_start <= 1'b1;
                        state   <= WAIT_ACC;
                    end else if (!rw_q) begin
                        if (!tx_empty) begin
                            m_data  <= tx_head;
                            m_rw    <= 1'b0;
                            m_start <= 1'b1;
                            idx_q   <= idx_q + 1'b1;
                            state   <= WAIT_ACC;
                        end
                    end else if (!rx_full) begin
                        m_rw    <= 1'b1;
                        m_start <= 1'b1;
                        idx_q   <= idx_q + 1'b1;
                        state   <= WAIT_ACC;
                    end
                end
                WAIT_ACC: begin
                    if (m_proc_ing) begin
                        m_start <= 1'b0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (m_done) begin
                        addr_phase <= 1'b0;
                        // Only bytes we send can be NACKed; read data acks belong to the engine.
                        if ((addr_phase || !rw_q) && !m_ack) begin
                            nack_err <= 1'b1;
                            m_stop   <= 1'b1;
                            state    <= STOP;
                        end else if (idx_q == len_q) begin
                            m_stop <= 1'b1;
                            state  <= STOP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                STOP: begin
                    xfer_done <= 1'b1;
                    state     <= FIN;
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iic_xfer_seq.sv
// Directed bench for iic_xfer_seq with a behavioural byte engine answering each m_start request.
module tb_iic_xfer_seq;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_dev_addr = '0;
    logic [3:0] cmd_len = '0;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_full;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       busy;
    logic       xfer_done;
    logic       nack_err;
    logic       m_rw;
    logic [1:0] m_mode;
    logic [7:0] m_data;
    logic       m_start;
    logic       m_stop;
    logic       m_proc_ing;
    logic       m_done;
    logic [7:0] m_data_out;
    logic       m_ack;

    always #5 clk = ~clk;

    iic_xfer_seq #(.FIFO_DEPTH(DEPTH), .BUS_MODE(2'd3)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_rw       (cmd_rw),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_len      (cmd_len),
        .tx_wr        (tx_wr),
        .tx_data      (tx_data),
        .tx_full      (tx_full),
        .rx_rd        (rx_rd),
        .rx_data      (rx_data),
        .rx_empty     (rx_empty),
        .busy         (busy),
        .xfer_done    (xfer_done),
        .nack_err     (nack_err),
        .m_rw         (m_rw),
        .m_mode       (m_mode),
        .m_data       (m_data),
        .m_start      (m_start),
        .m_stop       (m_stop),
        .m_proc_ing   (m_proc_ing),
        .m_done       (m_done),
        .m_data_out   (m_data_out),
        .m_ack        (m_ack)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         stop_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] log_dat[$];
    logic       log_rw[$];
    logic [7:0] rd_q[$];
    logic       eng_nack = 1'b0;

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        if (i < log_dat.size()) return {24'h0, log_dat[i]};
        return 32'hDEAD;
    endfunction

    function automatic logic [31:0] rw_at(input int i);
        if (i < log_rw.size()) return {31'h0, log_rw[i]};
        return 32'hDEAD;
    endfunction

    always @(negedge clk) begin
        if (m_stop) stop_cnt++;
        if (xfer_done) done_cnt++;
    end

    // Byte engine: accept on m_start, busy one cycle, then a one-cycle done.
    initial begin
        m_proc_ing = 1'b0;
        m_done     = 1'b0;
        m_ack      = 1'b1;
        m_data_out = '0;
        forever begin
            @(negedge clk);
            if (m_start && !rst) begin
                log_dat.push_back(m_data);
                log_rw.push_back(m_rw);
                m_proc_ing = 1'b1;
                @(negedge clk);
                m_done     = 1'b1;
                m_ack      = !eng_nack;
                m_data_out = (m_rw && rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
                @(negedge clk);
                m_done     = 1'b0;
                m_proc_ing = 1'b0;
            end
        end
    end

    task automatic tx_push(input logic [7:0] b);
        tx_wr   = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic send_cmd(input logic rw, input logic [6:0] addr, input logic [3:0] len);
        cmd_valid    = 1'b1;
        cmd_rw       = rw;
        cmd_dev_addr = addr;
        cmd_len      = len;
        @(negedge clk);
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (xfer_done) seen = 1'b1;
            else @(negedge clk);
        end
        check_vec({tag, "_done"}, {31'h0, seen}, 32'h1);
        @(negedge clk);
    endtask

    task automatic rx_pop(input string tag, input logic [7:0] exp);
        check_vec({tag, "_nonempty"}, {31'h0, rx_empty}, 32'h0);
        check_vec(tag, {24'h0, rx_data}, {24'h0, exp});
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
    endtask

    initial begin
        int  stop_base;
        int  done_base;
        logic start_seen;
        logic hit;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_vec("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check_vec("rst_busy",      {31'h0, busy},      32'h0);
        check_vec("rst_xfer_done", {31'h0, xfer_done}, 32'h0);
        check_vec("rst_nack",      {31'h0, nack_err},  32'h0);
        check_vec("rst_m_start",   {31'h0, m_start},   32'h0);
        check_vec("rst_m_stop",    {31'h0, m_stop},    32'h0);
        check_vec("rst_m_rw",      {31'h0, m_rw},      32'h0);
        check_vec("rst_m_data",    {24'h0, m_data},    32'h0);
        check_vec("rst_tx_full",   {31'h0, tx_full},   32'h0);
        check_vec("rst_rx_empty",  {31'h0, rx_empty},  32'h1);
        check_vec("rst_rx_data",   {24'h0, rx_data},   32'h0);
        check_vec("rst_m_mode",    {30'h0, m_mode},    32'h3);

        // Plain write of two bytes
        log_dat.delete(); log_rw.delete();
        stop_base = stop_cnt; done_base = done_cnt;
        tx_push(8'h01);
        tx_push(8'h02);
        send_cmd(1'b0, 7'h50, 4'd2);
        check_vec("wr_busy", {31'h0, busy}, 32'h1);
        wait_done("wr");
        check_vec("wr_nbytes", log_dat.size(), 32'd3);
        check_vec("wr_b0", log_at(0), 32'hA0);
        check_vec("wr_b1", log_at(1), 32'h01);
        check_vec("wr_b2", log_at(2), 32'h02);
        check_vec("wr_rw1", rw_at(1), 32'h0);
        check_vec("wr_stops", stop_cnt - stop_base, 32'd1);
        check_vec("wr_dones", done_cnt - done_base, 32'd1);
        check_vec("wr_nack", {31'h0, nack_err}, 32'h0);
        check_vec("wr_ready", {31'h0, cmd_ready}, 32'h1);

        // Read of three bytes
        log_dat.delete(); log_rw.delete();
        rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33);
        send_cmd(1'b1, 7'h50, 4'd3);
        wait_done("rd");
        check_vec("rd_nbytes", log_dat.size(), 32'd4);
        check_vec("rd_addr", log_at(0), 32'hA1);
        check_vec("rd_addr_rw", rw_at(0), 32'h0);
        check_vec("rd_rw1", rw_at(1), 32'h1);
        check_vec("rd_rw3", rw_at(3), 32'h1);
        rx_pop("rd_pop0", 8'h11);
        rx_pop("rd_pop1", 8'h22);
        rx_pop("rd_pop2", 8'h33);
        check_vec("rd_empty", {31'h0, rx_empty}, 32'h1);
        rx_rd = 1'b1;
        @(negedge clk);
        rx_rd = 1'b0;
        check_vec("rd_empty_pop_empty", {31'h0, rx_empty}, 32'h1);
        check_vec("rd_empty_pop_data", {24'h0, rx_data}, 32'h0);

        // NACK on address byte: abort, TX bytes survive
        log_dat.delete(); log_rw.delete();
        stop_base = stop_cnt; done_base = done_cnt;
        tx_push(8'hAA);
        tx_push(8'hBB);
        eng_nack = 1'b1;
        send_cmd(1'b0, 7'h50, 4'd2);
        wait_done("nk");
        eng_nack = 1'b0;
        check_vec("nk_nack", {31'h0, nack_err}, 32'h1);
        check_vec("nk_nbytes", log_dat.size(), 32'd1);
        check_vec("nk_addr", log_at(0), 32'hA0);
        check_vec("nk_stops", stop_cnt - stop_base, 32'd1);
        check_vec("nk_dones", done_cnt - done_base, 32'd1);
        log_dat.delete(); log_rw.delete();
        send_cmd(1'b0, 7'h50, 4'd2);
        check_vec("nk_clear", {31'h0, nack_err}, 32'h0);
        wait_done("nk_retry");
        check_vec("nk_retry_b1", log_at(1), 32'hAA);
        check_vec("nk_retry_b2", log_at(2), 32'hBB);

        // Stall on empty TX until the host supplies the second byte
        log_dat.delete(); log_rw.delete();
        tx_push(8'h5C);
        send_cmd(1'b0, 7'h21, 4'd2);
        start_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i >= 15) start_seen = start_seen | m_start;
        end
        check_vec("st_nbytes", log_dat.size(), 32'd2);
        check_vec("st_addr", log_at(0), 32'h42);
        check_vec("st_b1", log_at(1), 32'h5C);
        check_vec("st_start_low", {31'h0, start_seen}, 32'h0);
        check_vec("st_busy", {31'h0, busy}, 32'h1);
        tx_push(8'h7E);
        wait_done("st");
        check_vec("st_b2", log_at(2), 32'h7E);
        check_vec("st_total", log_dat.size(), 32'd3);

        // TX overflow: ninth byte is dropped
        log_dat.delete(); log_rw.delete();
        for (int i = 0; i < 8; i++) tx_push(8'h10 + 8'(i));
        check_vec("ff_full8", {31'h0, tx_full}, 32'h1);
        tx_push(8'h18);
        check_vec("ff_full9", {31'h0, tx_full}, 32'h1);
        send_cmd(1'b0, 7'h50, 4'd8);
        wait_done("ff");
        check_vec("ff_nbytes", log_dat.size(), 32'd9);
        check_vec("ff_first", log_at(1), 32'h10);
        check_vec("ff_last", log_at(8), 32'h17);
        check_vec("ff_not_full", {31'h0, tx_full}, 32'h0);

        // Reset while the address byte sits in WAIT_DONE
        log_dat.delete(); log_rw.delete();
        tx_push(8'h01);
        send_cmd(1'b0, 7'h50, 4'd1);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (m_proc_ing && !m_start && busy) hit = 1'b1;
            else @(negedge clk);
        end
        check_vec("ar_reached", {31'h0, hit}, 32'h1);
        stop_base = stop_cnt;
        rst = 1'b1;
        #1;
        check_vec("ar_busy",    {31'h0, busy},      32'h0);
        check_vec("ar_ready",   {31'h0, cmd_ready}, 32'h1);
        check_vec("ar_m_start", {31'h0, m_start},   32'h0);
        check_vec("ar_m_stop",  {31'h0, m_stop},    32'h0);
        check_vec("ar_m_data",  {24'h0, m_data},    32'h0);
        check_vec("ar_done",    {31'h0, xfer_done}, 32'h0);
        check_vec("ar_rx_empty",{31'h0, rx_empty},  32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_vec("ar_ready_post", {31'h0, cmd_ready}, 32'h1);
        check_vec("ar_no_stop", stop_cnt - stop_base, 32'd0);
        check_vec("ar_m_mode", {30'h0, m_mode}, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
